// File: rtl/wb_to_avalon_master.sv
// Wishbone classic slave to Avalon-MM master bridge.
// One transfer is in flight at a time. Every bus-facing output is registered.
//
// Handshake semantics:
//   Wishbone side: a request is taken only in IDLE, when wb_cyc_i & wb_stb_i
//   are both high. It is answered by a one-cycle wb_ack_o or wb_err_o, and
//   never by both. wb_stb_i is ignored while a transfer is in progress.
//   Avalon side: m_read/m_write are held stable with address, byteenable and
//   writedata until a cycle with m_waitrequest=0. Read data is taken on the
//   first m_readdatavalid seen in RDATA and ignored in every other state.
//   If wb_cyc_i drops mid-transfer, the Avalon side still finishes, but the
//   Wishbone response is suppressed.
module wb_to_avalon_master #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [29:0] m_address,
  output logic [3:0]  m_byteenable,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  input  logic        m_waitrequest,
  input  logic        m_readdatavalid,
  output logic [2:0]  o_dbg_state
);

  // The counter only has to reach TIMEOUT-1, so it is sized for that value.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_RDATA = 3'd2,
    S_ACK   = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            w_start;
  logic            w_rdone;
  logic            w_abort;
  logic            w_tmo_hit;
  logic            r_we;
  logic            r_abort;
  logic [CW-1:0]   r_cnt;
  logic            r_read;
  logic            r_write;
  logic            r_ack;
  logic            r_err;
  logic [29:0]     r_address;
  logic [3:0]      r_byteenable;
  logic [31:0]     r_writedata;
  logic [31:0]     r_rdata;

  assign wb_dat_o     = r_rdata;
  assign wb_ack_o     = r_ack;
  assign wb_err_o     = r_err;
  assign m_address    = r_address;
  assign m_byteenable = r_byteenable;
  assign m_read       = r_read;
  assign m_write      = r_write;
  assign m_writedata  = r_writedata;
  assign o_dbg_state  = r_state;

  // State register; reset overrides any transfer in progress.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode.
  // Avalon completion takes priority over a timeout that falls in the same cycle.
  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_rdone   = 1'b0;
    w_abort   = r_abort | ~wb_cyc_i;
    w_tmo_hit = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));
    case (r_state)
      S_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          w_next  = S_CMD;
          w_start = 1'b1;
        end
      end
      S_CMD: begin
        if (!m_waitrequest) begin
          if (r_we) w_next = w_abort ? S_IDLE : S_ACK;
          else      w_next = S_RDATA;
        end else if (w_tmo_hit) begin
          w_next = w_abort ? S_IDLE : S_ERR;
        end
      end
      S_RDATA: begin
        if (m_readdatavalid) begin
          w_rdone = 1'b1;
          w_next  = w_abort ? S_IDLE : S_ACK;
        end else if (w_tmo_hit) begin
          w_next = w_abort ? S_IDLE : S_ERR;
        end
      end
      S_ACK:   w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Registered outputs, latched request fields, abort flag and timeout counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we         <= 1'b0;
      r_abort      <= 1'b0;
      r_cnt        <= '0;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_ack        <= 1'b0;
      r_err        <= 1'b0;
      r_address    <= '0;
      r_byteenable <= '0;
      r_writedata  <= '0;
      r_rdata      <= '0;
    end else begin
      r_ack <= (w_next == S_ACK);
      r_err <= (w_next == S_ERR);
      if (w_start) begin
        r_address    <= wb_adr_i;
        r_byteenable <= wb_sel_i;
        r_writedata  <= wb_dat_i;
        r_we         <= wb_we_i;
        r_read       <= ~wb_we_i;
        r_write      <= wb_we_i;
        r_cnt        <= '0;
        r_abort      <= 1'b0;
      end else begin
        if (r_state == S_CMD && w_next != S_CMD) begin
          r_read  <= 1'b0;
          r_write <= 1'b0;
        end
        if (r_state == S_CMD || r_state == S_RDATA) begin
          r_abort <= w_abort;
          if (r_cnt != {CW{1'b1}}) r_cnt <= r_cnt + 1'b1;
        end
      end
      if (w_rdone) r_rdata <= m_readdata;
    end
  end

endmodule

// File: tb/tb_wb_to_avalon_master.sv
// Directed bench for wb_to_avalon_master, built with TIMEOUT=8.
// It runs a table of zero-wait-state transfers, then hand-written sequences
// for wait states, timeout, a dropped cycle, reset mid-read and back-to-back writes.
`timescale 1ns/1ps
module tb_wb_to_avalon_master;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic [29:0] m_address;
  logic [3:0]  m_byteenable;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;
  logic        m_waitrequest;
  logic        m_readdatavalid;
  logic [2:0]  o_dbg_state;

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  int err_cnt = 0;
  int a0, e0;

  typedef struct {
    logic        we;
    logic [29:0] adr;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [31:0] rdata;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t        vecs[5];
  logic [31:0] bb[3];

  wb_to_avalon_master #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
    .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .m_address(m_address), .m_byteenable(m_byteenable),
    .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
    .m_readdata(m_readdata), .m_waitrequest(m_waitrequest),
    .m_readdatavalid(m_readdatavalid), .o_dbg_state(o_dbg_state)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Watchdog: stop the run if the sequences ever stall.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one cycle and settle. Also count response pulses and
  // check that ack and err are never high together.
  task automatic tick();
    @(posedge clk);
    #1;
    ack_cnt += int'(wb_ack_o);
    err_cnt += int'(wb_err_o);
    chk("ack_err_exclusive", {31'd0, wb_ack_o & wb_err_o}, 32'd0);
  endtask

  task automatic req(input logic we, input logic [29:0] adr, input logic [3:0] sel,
                     input logic [31:0] dat);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_sel_i = sel;
    wb_dat_i = dat;
  endtask

  task automatic idle_bus();
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
  endtask

  // One zero-wait-state transfer; request is sampled at the end of cycle N.
  task automatic run_vec(input vec_t v);
    req(v.we, v.adr, v.sel, v.wdat);
    m_waitrequest = 1'b0;
    tick();  // N+1: command on Avalon
    chk("cmd_read",  {31'd0, m_read},  {31'd0, ~v.we});
    chk("cmd_write", {31'd0, m_write}, {31'd0, v.we});
    chk("cmd_addr",  {2'd0, m_address}, {2'd0, v.adr});
    chk("cmd_be",    {28'd0, m_byteenable}, {28'd0, v.sel});
    chk("cmd_wdata", m_writedata, v.wdat);
    chk("cmd_noack", {31'd0, wb_ack_o}, 32'd0);
    if (!v.we) begin
      tick();  // N+2: RDATA, command dropped
      chk("rd_cmd_drop", {31'd0, m_read}, 32'd0);
      chk("rd_noack",    {31'd0, wb_ack_o}, 32'd0);
      m_readdatavalid = 1'b1;
      m_readdata      = v.rdata;
    end
    tick();  // write: N+2, read: N+3
    m_readdatavalid = 1'b0;
    chk("resp_ack",  {31'd0, wb_ack_o}, 32'd1);
    chk("resp_err",  {31'd0, wb_err_o}, 32'd0);
    chk("resp_cmd",  {30'd0, m_read, m_write}, 32'd0);
    chk("resp_dat",  wb_dat_o, v.exp_dat);
    idle_bus();
    tick();
    chk("ack_one_cycle", {31'd0, wb_ack_o}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{we: 1'b1, adr: 30'h0000100, sel: 4'hF, wdat: 32'hDEADBEEF,
                rdata: 32'h0, exp_dat: 32'h00000000};
    vecs[1] = '{we: 1'b0, adr: 30'h3FFFFFFF, sel: 4'h1, wdat: 32'h11111111,
                rdata: 32'hA5A5A5A5, exp_dat: 32'hA5A5A5A5};
    vecs[2] = '{we: 1'b1, adr: 30'h2AAAAAAA, sel: 4'h5, wdat: 32'h00000000,
                rdata: 32'h0, exp_dat: 32'hA5A5A5A5};
    vecs[3] = '{we: 1'b0, adr: 30'h0000000, sel: 4'hF, wdat: 32'h22222222,
                rdata: 32'hFFFFFFFF, exp_dat: 32'hFFFFFFFF};
    vecs[4] = '{we: 1'b1, adr: 30'h0000001, sel: 4'h8, wdat: 32'h12345678,
                rdata: 32'h0, exp_dat: 32'hFFFFFFFF};
    bb[0] = 32'h11110000;
    bb[1] = 32'h22220000;
    bb[2] = 32'h33330000;

    reset = 1'b1;
    idle_bus();
    wb_we_i = 1'b0; wb_adr_i = '0; wb_sel_i = '0; wb_dat_i = '0;
    m_readdata = '0; m_waitrequest = 1'b0; m_readdatavalid = 1'b0;
    tick();
    tick();
    chk("rst_outputs", {wb_ack_o, wb_err_o, m_read, m_write, 28'd0}, 32'd0);
    chk("rst_addr",    {2'd0, m_address}, 32'd0);
    chk("rst_be",      {28'd0, m_byteenable}, 32'd0);
    chk("rst_wdata",   m_writedata, 32'd0);
    chk("rst_rdata",   wb_dat_o, 32'd0);
    chk("rst_state",   {29'd0, o_dbg_state}, 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Read with 3 wait states, stray readdatavalid during CMD, data 2 cycles after accept.
    a0 = ack_cnt;
    req(1'b0, 30'h0ABCDEF, 4'hF, 32'h0);
    m_waitrequest = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("ws_cmd_held", {31'd0, m_read}, 32'd1);
      chk("ws_addr_held", {2'd0, m_address}, {2'd0, 30'h0ABCDEF});
      if (i == 1) begin m_readdatavalid = 1'b1; m_readdata = 32'hBAD0BAD0; end
      if (i == 2) m_readdatavalid = 1'b0;
      if (i == 4) m_waitrequest = 1'b0;
    end
    tick();
    chk("ws_cmd_drop", {31'd0, m_read}, 32'd0);
    tick();
    m_readdatavalid = 1'b1;
    m_readdata      = 32'h12345678;
    tick();
    m_readdatavalid = 1'b0;
    chk("ws_ack", {31'd0, wb_ack_o}, 32'd1);
    chk("ws_dat", wb_dat_o, 32'h12345678);
    idle_bus();
    tick();
    chk("ws_ack_count", ack_cnt - a0, 1);

    // Timeout: waitrequest stuck high with TIMEOUT=8, then a late readdatavalid.
    a0 = ack_cnt; e0 = err_cnt;
    req(1'b0, 30'h0001234, 4'h3, 32'h0);
    m_waitrequest = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("to_cmd_held", {31'd0, m_read}, 32'd1);
    end
    tick();
    chk("to_cmd_drop", {31'd0, m_read}, 32'd0);
    chk("to_err",      {31'd0, wb_err_o}, 32'd1);
    chk("to_state",    {29'd0, o_dbg_state}, 32'd4);
    idle_bus();
    tick();
    chk("to_err_one_cycle", {31'd0, wb_err_o}, 32'd0);
    m_readdatavalid = 1'b1;
    m_readdata      = 32'hCAFEF00D;
    tick();
    m_readdatavalid = 1'b0;
    tick();
    chk("to_late_data_ignored", wb_dat_o, 32'h12345678);
    chk("to_err_count", err_cnt - e0, 1);
    chk("to_ack_count", ack_cnt - a0, 0);
    m_waitrequest = 1'b0;

    // Wishbone cycle dropped during the CMD phase of a read.
    a0 = ack_cnt; e0 = err_cnt;
    req(1'b0, 30'h0000055, 4'hF, 32'h0);
    m_waitrequest = 1'b1;
    tick();
    chk("cd_cmd", {31'd0, m_read}, 32'd1);
    idle_bus();
    tick();
    chk("cd_cmd_held", {31'd0, m_read}, 32'd1);
    m_waitrequest = 1'b0;
    tick();
    chk("cd_cmd_drop", {31'd0, m_read}, 32'd0);
    m_readdatavalid = 1'b1;
    m_readdata      = 32'h0BADF00D;
    tick();
    m_readdatavalid = 1'b0;
    chk("cd_state_idle", {29'd0, o_dbg_state}, 32'd0);
    tick();
    chk("cd_no_ack", ack_cnt - a0, 0);
    chk("cd_no_err", err_cnt - e0, 0);
    run_vec('{we: 1'b1, adr: 30'h0000077, sel: 4'hC, wdat: 32'h5A5A5A5A,
              rdata: 32'h0, exp_dat: 32'h0BADF00D});

    // Reset asserted while waiting for read data.
    req(1'b0, 30'h0000099, 4'hF, 32'h0);
    m_waitrequest = 1'b0;
    tick();
    tick();
    chk("rr_in_rdata", {29'd0, o_dbg_state}, 32'd2);
    reset = 1'b1;
    m_readdatavalid = 1'b1;
    m_readdata      = 32'h77777777;
    tick();
    chk("rr_outputs", {wb_ack_o, wb_err_o, m_read, m_write, 28'd0}, 32'd0);
    chk("rr_addr",    {2'd0, m_address}, 32'd0);
    chk("rr_be",      {28'd0, m_byteenable}, 32'd0);
    chk("rr_wdata",   m_writedata, 32'd0);
    chk("rr_rdata",   wb_dat_o, 32'd0);
    chk("rr_state",   {29'd0, o_dbg_state}, 32'd0);
    reset = 1'b0;
    m_readdatavalid = 1'b0;
    idle_bus();
    tick();
    chk("rr_no_resp", {30'd0, wb_ack_o, wb_err_o}, 32'd0);

    // Back-to-back writes with stb held high: one ack every 3 cycles.
    a0 = ack_cnt;
    req(1'b1, 30'h0000200, 4'hF, bb[0]);
    m_waitrequest = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("bb_write", {31'd0, m_write},  {31'd0, (k % 3) == 1});
      chk("bb_ack",   {31'd0, wb_ack_o}, {31'd0, (k % 3) == 2});
      if ((k % 3) == 1) chk("bb_wdata", m_writedata, bb[(k - 1) / 3]);
      if ((k % 3) == 2) begin
        if (k / 3 < 2) wb_dat_i = bb[k / 3 + 1];
        else           idle_bus();
      end
    end
    chk("bb_ack_count", ack_cnt - a0, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
